// File: rtl/i2c_rx_controller_if.sv
// I2C receive-side bundle: bus lines in, received data and status out.
// Latency: none (wires only).
// Backpressure: none; data_valid is a strobe and cannot be stalled.
interface i2c_rx_controller_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addr_match;
  logic [7:0] byte_count;
  logic       busy;

  // Peripheral side: sees the (synchronized) bus, drives ACK and results.
  modport slave (
    input  scl, sda_in,
    output sda_oe, data_out, data_valid, addr_match, byte_count, busy
  );

  // Bus-master / observer side.
  modport master (
    output scl, sda_in,
    input  sda_oe, data_out, data_valid, addr_match, byte_count, busy
  );
endinterface

// File: rtl/i2c_rx_controller.sv
// I2C write-only target: matches a 7-bit address, ACKs, delivers data bytes.
// Latency: data_valid 1 clk after the SCL rise that completes a data byte.
// Backpressure: none; every accepted byte is ACKed and strobed out once.
module i2c_rx_controller #(
  parameter logic [6:0] ADDRESS = 7'h2A
) (
  input logic             clk,
  input logic             reset,
  i2c_rx_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t     state_q;
  logic       scl_q;
  logic       sda_q;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic [2:0] bit_cnt_q;
  logic       ack_pend_q;
  logic       sda_oe_q;
  logic [7:0] data_out_q;
  logic       data_valid_q;
  logic       addr_match_q;
  logic [7:0] byte_count_q;

  logic scl_rise;
  logic scl_fall;
  logic start_cond;
  logic stop_cond;

  // Bus events from the current line levels against their one-cycle-old copies.
  always_comb begin
    scl_rise   = !scl_q & bus.scl;
    scl_fall   = scl_q & !bus.scl;
    start_cond = bus.scl & scl_q & sda_q & !bus.sda_in;
    stop_cond  = bus.scl & scl_q & !sda_q & bus.sda_in;
    shift_d    = {shift_q[6:0], bus.sda_in};
  end

  // Protocol FSM with all outputs registered; START beats STOP beats SCL edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      ack_pend_q   <= 1'b0;
      sda_oe_q     <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      addr_match_q <= 1'b0;
      byte_count_q <= 8'h00;
    end else begin
      scl_q        <= bus.scl;
      sda_q        <= bus.sda_in;
      data_valid_q <= 1'b0;
      if (start_cond) begin
        state_q      <= ADDR;
        bit_cnt_q    <= 3'd0;
        shift_q      <= 8'h00;
        ack_pend_q   <= 1'b0;
        addr_match_q <= 1'b0;
        sda_oe_q     <= 1'b0;
      end else if (stop_cond) begin
        state_q      <= IDLE;
        ack_pend_q   <= 1'b0;
        addr_match_q <= 1'b0;
        sda_oe_q     <= 1'b0;
      end else begin
        case (state_q)
          ADDR, DATA: begin
            if (ack_pend_q) begin
              // Byte done: drive ACK once SCL is low so the master sees it on the 9th clock.
              if (scl_fall) begin
                ack_pend_q <= 1'b0;
                sda_oe_q   <= 1'b1;
                state_q    <= (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
              end
            end else if (scl_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 3'd7) begin
                // Counter parks at 7; it only returns to 0 when the ACK slot ends.
                if (state_q == ADDR) begin
                  if (shift_d[7:1] == ADDRESS && !shift_d[0]) begin
                    addr_match_q <= 1'b1;
                    byte_count_q <= 8'h00;
                    ack_pend_q   <= 1'b1;
                  end else begin
                    state_q <= IGNORE;
                  end
                end else begin
                  data_out_q   <= shift_d;
                  data_valid_q <= 1'b1;
                  ack_pend_q   <= 1'b1;
                  if (byte_count_q != 8'hFF) begin
                    byte_count_q <= byte_count_q + 8'd1;
                  end
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            // Entered on a fall, so the next fall closes the 9th clock.
            if (scl_fall) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
              state_q   <= DATA;
            end
          end
          default: begin
            // IDLE and IGNORE wait for START/STOP only.
          end
        endcase
      end
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.addr_match = addr_match_q;
  assign bus.byte_count = byte_count_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
